// File: rtl/down_timer.sv
// Programmable down-counting timer with prescaler, one-shot and periodic modes.
// Flags expiry with a one-cycle tc pulse and a sticky irq.
module down_timer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  periodic,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear_irq,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  tc,
    output logic                  irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [WIDTH-1:0]        count_n;
    logic [WIDTH-1:0]        reload;
    logic [WIDTH-1:0]        reload_n;
    logic [PRESCALE_W-1:0]   psc;
    logic [PRESCALE_W-1:0]   psc_n;
    logic                    tc_n;
    logic                    irq_n;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            psc    <= '0;
            tc     <= 1'b0;
            irq    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            reload <= reload_n;
            psc    <= psc_n;
            tc     <= tc_n;
            irq    <= irq_n;
            busy   <= (state_n == RUN);
        end
    end

    // Next-state logic; irq set on expiry overrides a simultaneous clear
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload;
        psc_n    = psc;
        tc_n     = 1'b0;
        irq_n    = irq & ~clear_irq;

        case (state)
            IDLE, DONE: begin
                if (start && !stop && (reload != '0)) begin
                    state_n = RUN;
                    psc_n   = '0;
                    if (state == DONE) begin
                        count_n = reload;
                    end
                end
                if (load) begin
                    reload_n = load_val;
                    count_n  = load_val;
                end
            end
            RUN: begin
                if (load) begin
                    reload_n = load_val;
                end
                if (stop) begin
                    state_n = IDLE;
                    psc_n   = '0;
                end else if (en) begin
                    if (psc == prescale) begin
                        psc_n = '0;
                        if (count > WIDTH'(1)) begin
                            count_n = count - WIDTH'(1);
                        end else if (count == WIDTH'(1)) begin
                            tc_n  = 1'b1;
                            irq_n = 1'b1;
                            if (periodic) begin
                                // reload_n already carries a same-cycle load_val
                                count_n = reload_n;
                            end else begin
                                count_n = '0;
                                state_n = DONE;
                            end
                        end
                    end else begin
                        psc_n = psc + PRESCALE_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: tick-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_down_timer;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned PRESCALE_W = 8;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic                  load;
    logic [WIDTH-1:0]      load_val;
    logic [PRESCALE_W-1:0] prescale;
    logic                  periodic;
    logic                  start;
    logic                  stop;
    logic                  clear_irq;
    logic [WIDTH-1:0]      count;
    logic                  busy;
    logic                  tc;
    logic                  irq;

    int n_checks = 0;
    int n_fail   = 0;

    down_timer #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .prescale(prescale), .periodic(periodic), .start(start), .stop(stop),
        .clear_irq(clear_irq), .count(count), .busy(busy), .tc(tc), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: running flag, remaining ticks, and enabled cycles into the current tick
    bit          m_running;
    bit          m_done;
    int unsigned m_count;
    int unsigned m_reload;
    int unsigned m_phase;
    bit          m_tc;
    bit          m_irq;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_running = 0; m_done = 0; m_count = 0; m_reload = 0;
            m_phase = 0; m_tc = 0; m_irq = 0;
        end else begin
            int unsigned old_reload;
            old_reload = m_reload;
            m_tc = 0;
            if (clear_irq) m_irq = 0;
            if (!m_running) begin
                if (start && !stop && old_reload != 0) begin
                    m_running = 1;
                    m_phase   = 0;
                    if (m_done) m_count = old_reload;
                    m_done = 0;
                end
                if (load) begin
                    m_reload = load_val;
                    m_count  = load_val;
                end
            end else begin
                if (load) m_reload = load_val;
                if (stop) begin
                    m_running = 0;
                    m_phase   = 0;
                end else if (en) begin
                    m_phase++;
                    if (m_phase == int'(prescale) + 1) begin
                        m_phase = 0;
                        if (m_count > 1) m_count--;
                        else if (m_count == 1) begin
                            m_tc  = 1;
                            m_irq = 1;
                            if (periodic) m_count = m_reload;
                            else begin
                                m_count   = 0;
                                m_running = 0;
                                m_done    = 1;
                            end
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        chk("model_count", count, m_count);
        chk("model_busy",  32'(busy), 32'(m_running));
        chk("model_tc",    32'(tc),   32'(m_tc));
        chk("model_irq",   32'(irq),  32'(m_irq));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v);
        load = 1'b1; load_val = v;
        step();
        load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b0; en = 1'b1; load = 1'b0; load_val = '0; prescale = '0;
        periodic = 1'b0; start = 1'b0; stop = 1'b0; clear_irq = 1'b0;
        step(); step();
        chk("reset_count", count, 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_tc", 32'(tc), 0);
        chk("reset_irq", 32'(irq), 0);
        rst = 1'b1;
        step();

        // One-shot, load 3, prescale 0
        do_load(3);
        do_start();
        chk("t1_count_i0", count, 3);
        chk("t1_busy_i0", 32'(busy), 1);
        step(); chk("t1_count_i1", count, 2);
        step(); chk("t1_count_i2", count, 1); chk("t1_tc_i2", 32'(tc), 0);
        step();
        chk("t1_tc_i3", 32'(tc), 1);
        chk("t1_count_i3", count, 0);
        chk("t1_busy_i3", 32'(busy), 0);
        chk("t1_irq_i3", 32'(irq), 1);
        step(); chk("t1_tc_i4", 32'(tc), 0);
        clear_irq = 1'b1; step(); clear_irq = 1'b0;
        chk("t1_irq_cleared", 32'(irq), 0);

        // Periodic, load 2, prescale 3: tc every 8 cycles with no reload gap
        prescale = 8'd3; periodic = 1'b1;
        do_load(2);
        do_start();
        for (int i = 1; i <= 24; i++) begin
            step();
            chk("t2_tc", 32'(tc), (i % 8 == 0) ? 1 : 0);
            chk("t2_busy", 32'(busy), 1);
            if (i == 8) chk("t2_count_reload", count, 2);
        end
        stop = 1'b1; step(); stop = 1'b0;
        chk("t2_busy_stopped", 32'(busy), 0);

        // Enable drop for 4 cycles delays expiry by 4
        prescale = 8'd0; periodic = 1'b0;
        do_load(5);
        do_start();
        chk("t3_count_i0", count, 5);
        step(); chk("t3_count_i1", count, 4);
        en = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            step();
            chk("t3_count_frozen", count, 4);
        end
        en = 1'b1;
        step(); chk("t3_count_i6", count, 3);
        step(); chk("t3_count_i7", count, 2);
        step(); chk("t3_tc_i8", 32'(tc), 0);
        step();
        chk("t3_tc_i9", 32'(tc), 1);
        chk("t3_busy_i9", 32'(busy), 0);

        // Stop on the expiring tick, then clear_irq colliding with expiry
        clear_irq = 1'b1; step(); clear_irq = 1'b0;
        chk("t4_irq_pre", 32'(irq), 0);
        do_load(2);
        do_start();
        step(); chk("t4_count_i1", count, 1);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t4_stop_tc", 32'(tc), 0);
        chk("t4_stop_irq", 32'(irq), 0);
        chk("t4_stop_busy", 32'(busy), 0);
        chk("t4_stop_count", count, 1);
        do_start();
        chk("t4_restart_count", count, 1);
        clear_irq = 1'b1; step(); clear_irq = 1'b0;
        chk("t4_clr_tc", 32'(tc), 1);
        chk("t4_clr_irq", 32'(irq), 1);

        // Asynchronous reset mid-run
        prescale = 8'd10;
        do_load(7);
        do_start();
        step(); step();
        chk("t5_count_pre", count, 7);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_count", count, 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_irq", 32'(irq), 0);
        #2 rst = 1'b1;
        do_start();
        chk("t5_start_ignored", 32'(busy), 0);

        // Periodic reload picks up a load made while running
        prescale = 8'd0; periodic = 1'b1;
        do_load(2);
        do_start();
        chk("t6_count_i0", count, 2);
        do_load(4);
        chk("t6_count_i1", count, 1);
        step();
        chk("t6_tc_i2", 32'(tc), 1);
        chk("t6_count_i2", count, 4);
        step(); chk("t6_count_i3", count, 3);
        step(); chk("t6_count_i4", count, 2);
        step(); chk("t6_count_i5", count, 1); chk("t6_tc_i5", 32'(tc), 0);
        step();
        chk("t6_tc_i6", 32'(tc), 1);
        chk("t6_count_i6", count, 4);
        stop = 1'b1; step(); stop = 1'b0;
        chk("t6_busy_stopped", 32'(busy), 0);

        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
